pdt_tournament: RTL and testbench

Parametrised tournament branch predictor for the RV32I pipeline: local-history predictor, gshare global predictor and per-PC chooser, all clocked tables with a speculative global history register repaired on mispredict. It sits between IF and pc_reg: it predicts in the fetch cycle and is trained by the resolving stage. Over the first-generation predictor it adds proper clocked training, a clean reset sweep, chooser update only on disagreement, GHR repair, and always-taken JAL prediction.

---
 rtl/pdt_tournament_pkg.sv | 17 +
 rtl/pdt_sat_ctr.sv | 14 +
 rtl/pdt_tournament.sv | 124 ++++++++++++
 tb/tb_pdt_tournament.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdt_tournament_pkg.sv
// pdt_tournament_pkg: opcode constants, FSM state type and immediate decoders for the tournament predictor
package pdt_tournament_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic {INIT, RUN} state_t;

    function automatic logic [31:0] b_imm(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] j_imm(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/pdt_sat_ctr.sv
// pdt_sat_ctr: next value of a saturating up/down counter
module pdt_sat_ctr #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] value,
    input  logic             inc,
    input  logic             dec,
    output logic [CTR_W-1:0] next
);

    always_comb next = inc && value != '1 ? value + 1'b1 :
                       dec && value != '0 ? value - 1'b1 : value;

endmodule

// File: rtl/pdt_tournament.sv
// pdt_tournament: local/gshare tournament branch predictor with reset sweep and speculative GHR repair
module pdt_tournament
    import pdt_tournament_pkg::*;
#(
    parameter int IDX_W = 10,
    parameter int GHR_W = 10,
    parameter int LHR_W = 2,
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_inst,
    input  logic             if_stall,
    output logic             ready,
    output logic             branch_or_not,
    output logic [31:0]      pdt_pc,
    output logic             pdt_res,
    output logic [GHR_W-1:0] pdt_ghr,
    output logic [LHR_W-1:0] pdt_lhr,
    output logic             pdt_local,
    output logic             pdt_global,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic             upd_mispredict,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic [LHR_W-1:0] upd_lhr,
    input  logic             upd_local,
    input  logic             upd_global
);

    localparam int N = 1 << IDX_W;
    localparam logic [CTR_W-1:0] WEAK = CTR_W'((1 << (CTR_W - 1)) - 1);

    logic [CTR_W-1:0] lpht [N];
    logic [CTR_W-1:0] gpht [N];
    logic [CTR_W-1:0] cht  [N];
    logic [LHR_W-1:0] lht  [N];

    state_t           state, state_nxt;
    logic [IDX_W-1:0] sweep;
    logic [GHR_W-1:0] ghr;
    logic [IDX_W-1:0] i, li, gi, ui, uli, ugi;
    logic [LHR_W-1:0] lhr;
    logic             is_br, is_jal, lp, gp, sel, res, train;
    logic [CTR_W-1:0] lpht_nxt, gpht_nxt, cht_nxt;
    logic             unused;

    always_ff @(posedge clk)
        if (rst) state <= INIT;
        else state <= state_nxt;

    always_comb state_nxt = state == INIT && sweep == '1 ? RUN : state;

    always_comb ready = state == RUN;

    always_ff @(posedge clk)
        if (rst || ready) sweep <= '0;
        else sweep <= sweep + 1'b1;

    assign i   = if_pc[IDX_W+1:2];
    assign lhr = lht[i];
    assign li  = i ^ IDX_W'(lhr);
    assign gi  = i ^ IDX_W'(ghr);
    assign lp  = lpht[li][CTR_W-1];
    assign gp  = gpht[gi][CTR_W-1];
    assign sel = cht[i][CTR_W-1];

    assign is_br  = ready && if_inst[6:0] == OP_BRANCH;
    assign is_jal = ready && if_inst[6:0] == OP_JAL;
    assign res    = is_jal || (is_br && (sel ? gp : lp));

    always_comb begin
        branch_or_not = is_br || is_jal;
        pdt_res       = res;
        pdt_pc        = !ready ? '0 :
                        is_jal ? if_pc + j_imm(if_inst) :
                        res    ? if_pc + b_imm(if_inst) : if_pc + 32'd4;
        pdt_ghr       = ready ? ghr : '0;
        pdt_lhr       = ready ? lhr : '0;
        pdt_local     = ready && (is_jal || lp);
        pdt_global    = ready && (is_jal || gp);
    end

    assign train  = ready && !rst && upd_valid;
    assign ui     = upd_pc[IDX_W+1:2];
    assign uli    = ui ^ IDX_W'(upd_lhr);
    assign ugi    = ui ^ IDX_W'(upd_ghr);
    assign unused = ^{upd_pc[31:IDX_W+2], upd_pc[1:0]};

    pdt_sat_ctr #(.CTR_W(CTR_W)) u_lctr (
        .value(lpht[uli]), .inc(upd_taken), .dec(!upd_taken), .next(lpht_nxt)
    );

    pdt_sat_ctr #(.CTR_W(CTR_W)) u_gctr (
        .value(gpht[ugi]), .inc(upd_taken), .dec(!upd_taken), .next(gpht_nxt)
    );

    pdt_sat_ctr #(.CTR_W(CTR_W)) u_cctr (
        .value(cht[ui]), .inc(upd_global == upd_taken), .dec(upd_local == upd_taken), .next(cht_nxt)
    );

    // the reset sweep owns the write ports until every entry is initialised
    always_ff @(posedge clk)
        if (state == INIT) begin
            lpht[sweep] <= WEAK;
            gpht[sweep] <= WEAK;
            cht[sweep]  <= WEAK;
            lht[sweep]  <= '0;
        end else if (train) begin
            lpht[uli] <= lpht_nxt;
            gpht[ugi] <= gpht_nxt;
            lht[ui]   <= LHR_W'({upd_lhr, upd_taken});
            if (upd_local != upd_global) cht[ui] <= cht_nxt;
        end

    // repair from the resolved snapshot wins over the speculative shift
    always_ff @(posedge clk)
        if (rst || !ready) ghr <= '0;
        else if (train && upd_mispredict) ghr <= GHR_W'({upd_ghr, upd_taken});
        else if (is_br && !if_stall) ghr <= GHR_W'({ghr, res});

endmodule

// File: tb/tb_pdt_tournament.sv
// tb_pdt_tournament: directed and randomized checks of pdt_tournament against a table-level reference model
module tb_pdt_tournament;

    localparam int IDX_W = 10;
    localparam int GHR_W = 10;
    localparam int LHR_W = 2;
    localparam int CTR_W = 2;
    localparam int N     = 1 << IDX_W;
    localparam int IM    = N - 1;
    localparam int GM    = (1 << GHR_W) - 1;
    localparam int HM    = (1 << LHR_W) - 1;
    localparam int CMAX  = (1 << CTR_W) - 1;
    localparam int WEAK  = (1 << (CTR_W - 1)) - 1;

    logic             clk;
    logic             rst;
    logic [31:0]      if_pc;
    logic [31:0]      if_inst;
    logic             if_stall;
    logic             ready;
    logic             branch_or_not;
    logic [31:0]      pdt_pc;
    logic             pdt_res;
    logic [GHR_W-1:0] pdt_ghr;
    logic [LHR_W-1:0] pdt_lhr;
    logic             pdt_local;
    logic             pdt_global;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic             upd_taken;
    logic             upd_mispredict;
    logic [GHR_W-1:0] upd_ghr;
    logic [LHR_W-1:0] upd_lhr;
    logic             upd_local;
    logic             upd_global;

    pdt_tournament #(.IDX_W(IDX_W), .GHR_W(GHR_W), .LHR_W(LHR_W), .CTR_W(CTR_W)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_inst(if_inst), .if_stall(if_stall),
        .ready(ready), .branch_or_not(branch_or_not), .pdt_pc(pdt_pc), .pdt_res(pdt_res),
        .pdt_ghr(pdt_ghr), .pdt_lhr(pdt_lhr), .pdt_local(pdt_local), .pdt_global(pdt_global),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict), .upd_ghr(upd_ghr), .upd_lhr(upd_lhr),
        .upd_local(upd_local), .upd_global(upd_global)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference model: counter tables as plain integers, fetch described by kind and offset
    int ml [N];
    int mg [N];
    int mc [N];
    int mh [N];
    int mghr;
    int minit;
    int kind;
    int off;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input bit up);
        return up ? (v == CMAX ? CMAX : v + 1) : (v == 0 ? 0 : v - 1);
    endfunction

    function automatic logic [31:0] enc_b(input int o);
        logic [12:0] b;
        logic [12:0] r;
        b = o[12:0];
        r = 13'($urandom);
        return {b[12], b[10:5], r[12:3], r[2:0], b[4:1], b[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int o);
        logic [20:0] j;
        logic [4:0]  rd;
        j  = o[20:0];
        rd = 5'($urandom);
        return {j[20], j[10:1], j[11], j[19:12], rd, 7'b1101111};
    endfunction

    task automatic mreset();
        for (int k = 0; k < N; k++) begin
            ml[k] = WEAK;
            mg[k] = WEAK;
            mc[k] = WEAK;
            mh[k] = 0;
        end
        mghr  = 0;
        minit = N;
    endtask

    task automatic set_fetch(input logic [31:0] pc, input int k, input int o);
        logic [31:0] r;
        r       = $urandom;
        if_pc   = pc;
        kind    = k;
        off     = o;
        if_inst = k == 1 ? enc_b(o) : k == 2 ? enc_j(o) : {r[31:7], 7'b0010011};
    endtask

    task automatic idle_upd();
        upd_valid      = 1'b0;
        upd_pc         = '0;
        upd_taken      = 1'b0;
        upd_mispredict = 1'b0;
        upd_ghr        = '0;
        upd_lhr        = '0;
        upd_local      = 1'b0;
        upd_global     = 1'b0;
    endtask

    task automatic rand_in();
        int k;
        k = int'($urandom_range(0, 3));
        if (k <= 1) set_fetch(32'h400 + ($urandom_range(0, 15) << 2), 1, (int'($urandom_range(0, 4095)) - 2048) * 2);
        else if (k == 2) set_fetch(32'h400 + ($urandom_range(0, 15) << 2), 2, (int'($urandom_range(0, 65535)) - 32768) * 2);
        else set_fetch(32'h400 + ($urandom_range(0, 15) << 2), 3, 0);
        if_stall       = $urandom_range(0, 3) == 0;
        upd_valid      = $urandom_range(0, 1) == 1;
        upd_pc         = 32'h400 + ($urandom_range(0, 15) << 2);
        upd_taken      = 1'($urandom);
        upd_mispredict = 1'($urandom);
        upd_ghr        = GHR_W'($urandom);
        upd_lhr        = LHR_W'($urandom);
        upd_local      = 1'($urandom);
        upd_global     = 1'($urandom);
    endtask

    // check every output against the model, advance the model, then take one clock edge
    task automatic cyc();
        int          i, lh, lp, gp, ui, ng;
        logic        e_bon, e_res, e_loc, e_glb;
        logic [31:0] e_pc;
        #1;
        e_bon = 0; e_res = 0; e_loc = 0; e_glb = 0; e_pc = 0; lh = 0;
        if (minit == 0) begin
            i  = int'(if_pc >> 2) & IM;
            lh = mh[i];
            lp = ml[i ^ lh] >> (CTR_W - 1);
            gp = mg[i ^ mghr] >> (CTR_W - 1);
            e_loc = lp[0];
            e_glb = gp[0];
            e_pc  = if_pc + 32'd4;
            if (kind == 1) begin
                e_bon = 1;
                e_res = (mc[i] >> (CTR_W - 1)) != 0 ? gp[0] : lp[0];
                if (e_res) e_pc = if_pc + 32'(off);
            end else if (kind == 2) begin
                e_bon = 1; e_res = 1; e_loc = 1; e_glb = 1;
                e_pc  = if_pc + 32'(off);
            end
        end
        chk("ready", 32'(ready), 32'(minit == 0));
        chk("branch_or_not", 32'(branch_or_not), 32'(e_bon));
        chk("pdt_pc", pdt_pc, e_pc);
        chk("pdt_res", 32'(pdt_res), 32'(e_res));
        chk("pdt_ghr", 32'(pdt_ghr), minit == 0 ? 32'(mghr) : 32'd0);
        chk("pdt_lhr", 32'(pdt_lhr), 32'(lh));
        chk("pdt_local", 32'(pdt_local), 32'(e_loc));
        chk("pdt_global", 32'(pdt_global), 32'(e_glb));
        if (rst) mreset();
        else if (minit != 0) minit--;
        else begin
            ng = mghr;
            if (kind == 1 && !if_stall) ng = ((mghr << 1) | int'(e_res)) & GM;
            if (upd_valid) begin
                ui = int'(upd_pc >> 2) & IM;
                ml[ui ^ int'(upd_lhr)] = sat(ml[ui ^ int'(upd_lhr)], upd_taken);
                mg[ui ^ int'(upd_ghr)] = sat(mg[ui ^ int'(upd_ghr)], upd_taken);
                mh[ui] = ((int'(upd_lhr) << 1) | int'(upd_taken)) & HM;
                if (upd_local != upd_global) mc[ui] = sat(mc[ui], upd_global == upd_taken);
                if (upd_mispredict) ng = ((int'(upd_ghr) << 1) | int'(upd_taken)) & GM;
            end
            mghr = ng;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic init_wait();
        int n;
        n = 0;
        while (!ready && n < 2000) begin
            rand_in();
            cyc();
            n++;
        end
        chk("init_len", 32'(n), 32'(N));
        idle_upd();
        if_stall = 1'b0;
    endtask

    initial begin
        logic        p_res, p_loc, p_glb, act;
        logic [GHR_W-1:0] p_ghr;
        logic [LHR_W-1:0] p_lhr;
        int          g0;
        rst = 1'b1;
        if_stall = 1'b0;
        set_fetch(32'h0, 3, 0);
        idle_upd();
        @(posedge clk);
        #1;
        mreset();
        rst = 1'b0;
        chk("ready_after_rst", 32'(ready), 32'd0);
        init_wait();

        // untrained branch predicts not-taken
        set_fetch(32'h100, 1, 16);
        #1;
        chk("cold_res", 32'(pdt_res), 32'd0);
        chk("cold_pc", pdt_pc, 32'h104);
        cyc();

        // train 0x100 taken twice under the steady-taken local history
        set_fetch(32'h0, 3, 0);
        upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_lhr = 2'd3;
        cyc();
        cyc();
        idle_upd();
        set_fetch(32'h100, 1, 16);
        #1;
        chk("trained_res", 32'(pdt_res), 32'd1);
        chk("trained_pc", pdt_pc, 32'h110);
        cyc();

        // alternating branch: pipeline feeds back the snapshots it fetched with
        for (int it = 0; it < 16; it++) begin
            act = (it % 2) == 0;
            set_fetch(32'h300, 1, 32);
            idle_upd();
            #1;
            p_res = pdt_res; p_loc = pdt_local; p_glb = pdt_global; p_ghr = pdt_ghr; p_lhr = pdt_lhr;
            if (it >= 8) chk("alt_local", 32'(pdt_local), 32'(act));
            cyc();
            set_fetch(32'h0, 3, 0);
            upd_valid = 1'b1; upd_pc = 32'h300; upd_taken = act; upd_mispredict = p_res != act;
            upd_ghr = p_ghr; upd_lhr = p_lhr; upd_local = p_loc; upd_global = p_glb;
            cyc();
        end
        idle_upd();

        // JAL backwards by 8
        set_fetch(32'h200, 2, -8);
        #1;
        g0 = mghr;
        chk("jal_bon", 32'(branch_or_not), 32'd1);
        chk("jal_res", 32'(pdt_res), 32'd1);
        chk("jal_pc", pdt_pc, 32'h1F8);
        cyc();
        set_fetch(32'h0, 3, 0);
        #1;
        chk("jal_ghr", 32'(pdt_ghr), 32'(g0));
        cyc();

        // predicted-taken fetch with a same-cycle mispredict repair
        set_fetch(32'h100, 1, 16);
        upd_valid = 1'b1; upd_pc = 32'h500; upd_mispredict = 1'b1; upd_taken = 1'b0;
        upd_ghr = 10'h0AA; upd_global = 1'b1;
        #1;
        chk("repair_spec_res", 32'(pdt_res), 32'd1);
        cyc();
        idle_upd();
        set_fetch(32'h0, 3, 0);
        #1;
        chk("repair_ghr", 32'(pdt_ghr), 32'h154);
        cyc();

        for (int c = 0; c < 3000; c++) begin
            rand_in();
            cyc();
        end

        // reset from RUN; updates during the sweep must be ignored
        rst = 1'b1;
        rand_in();
        cyc();
        rst = 1'b0;
        chk("ready_after_run_rst", 32'(ready), 32'd0);
        init_wait();
        set_fetch(32'h100, 1, 16);
        #1;
        chk("reinit_res", 32'(pdt_res), 32'd0);
        chk("reinit_pc", pdt_pc, 32'h104);
        cyc();

        for (int c = 0; c < 500; c++) begin
            rand_in();
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
